// File: rtl/exc_commit_ctrl.sv
// Memory-stage exception arbiter and commit sequencer: picks the highest-priority
// cause, presents it to CP0 for one non-stalled cycle, then holds flush/redirect.
module exc_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_daddr_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_trap_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_eret_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  output logic        mem_kill_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic        busy_o
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               int_pend;
  logic               any_exc;
  logic               detect;
  logic [31:0]        sel_code;
  logic [31:0]        sel_bad;
  logic [31:0]        sel_newpc;

  // Status/Cause bits outside IE/EXL/IM/IP do not affect arbitration
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                             cp0_cause_i[31:16], cp0_cause_i[7:0]};

  assign int_pend = cp0_status_i[0] & ~cp0_status_i[1]
                  & (|(cp0_cause_i[15:8] & cp0_status_i[15:8]));

  assign any_exc = exc_adel_if_i | exc_ri_i | exc_ov_i | exc_trap_i | exc_sys_i
                 | exc_bp_i | exc_eret_i | exc_adel_ld_i | exc_ades_i;

  assign detect     = (state == IDLE) & ~stall_i & mem_valid_i & (int_pend | any_exc);
  assign mem_kill_o = detect & ~rst;

  // Priority select of cause code, bad address and redirect target
  always_comb begin
    sel_code  = 32'h0;
    sel_bad   = 32'h0;
    sel_newpc = EXC_VECTOR;
    if (int_pend) begin
      sel_code = 32'h01;
    end else if (exc_adel_if_i) begin
      sel_code = 32'h04;
      sel_bad  = mem_pc_i;
    end else if (exc_ri_i) begin
      sel_code = 32'h0a;
    end else if (exc_ov_i) begin
      sel_code = 32'h0c;
    end else if (exc_trap_i) begin
      sel_code = 32'h0d;
    end else if (exc_sys_i) begin
      sel_code = 32'h08;
    end else if (exc_bp_i) begin
      sel_code = 32'h09;
    end else if (exc_eret_i) begin
      sel_code  = 32'h0e;
      sel_newpc = cp0_epc_i;
    end else if (exc_adel_ld_i) begin
      sel_code = 32'h04;
      sel_bad  = mem_daddr_i;
    end else if (exc_ades_i) begin
      sel_code = 32'h05;
      sel_bad  = mem_daddr_i;
    end
  end

  // Sequencer; all CP0-facing and flush outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      excepttype_o        <= 32'h0;
      current_inst_addr_o <= 32'h0;
      is_in_delayslot_o   <= 1'b0;
      bad_addr_o          <= 32'h0;
      flush_o             <= 1'b0;
      newpc_o             <= 32'h0;
      busy_o              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (detect) begin
            state               <= COMMIT;
            excepttype_o        <= sel_code;
            current_inst_addr_o <= mem_pc_i;
            is_in_delayslot_o   <= mem_in_delayslot_i;
            bad_addr_o          <= sel_bad;
            newpc_o             <= sel_newpc;
            flush_o             <= 1'b1;
            busy_o              <= 1'b1;
          end
        end
        COMMIT: begin
          // CP0 ignores the port while stalled, so hold until a live cycle
          if (!stall_i) begin
            state        <= DRAIN;
            cnt          <= CNT_W'(DRAIN_CYCLES - 1);
            excepttype_o <= 32'h0;
          end
        end
        DRAIN: begin
          if (!stall_i) begin
            if (cnt == '0) begin
              state   <= IDLE;
              flush_o <= 1'b0;
              newpc_o <= 32'h0;
              busy_o  <= 1'b0;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          flush_o <= 1'b0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Directed bench for exc_commit_ctrl: expected commits are queued at detect time
// and checked when the block presents them to CP0.
module tb_exc_commit_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] npc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [31:0] mem_daddr_i;
  logic        exc_adel_if_i, exc_ri_i, exc_ov_i, exc_trap_i, exc_sys_i;
  logic        exc_bp_i, exc_eret_i, exc_adel_ld_i, exc_ades_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        mem_kill_o;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
  logic        is_in_delayslot_o, flush_o, busy_o;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t cur;

  exc_commit_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_i             (stall_i),
    .mem_valid_i         (mem_valid_i),
    .mem_pc_i            (mem_pc_i),
    .mem_in_delayslot_i  (mem_in_delayslot_i),
    .mem_daddr_i         (mem_daddr_i),
    .exc_adel_if_i       (exc_adel_if_i),
    .exc_ri_i            (exc_ri_i),
    .exc_ov_i            (exc_ov_i),
    .exc_trap_i          (exc_trap_i),
    .exc_sys_i           (exc_sys_i),
    .exc_bp_i            (exc_bp_i),
    .exc_eret_i          (exc_eret_i),
    .exc_adel_ld_i       (exc_adel_ld_i),
    .exc_ades_i          (exc_ades_i),
    .cp0_status_i        (cp0_status_i),
    .cp0_cause_i         (cp0_cause_i),
    .cp0_epc_i           (cp0_epc_i),
    .mem_kill_o          (mem_kill_o),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .bad_addr_o          (bad_addr_o),
    .flush_o             (flush_o),
    .newpc_o             (newpc_o),
    .busy_o              (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic clear_in();
    mem_valid_i = 1'b0; mem_pc_i = 32'h0; mem_in_delayslot_i = 1'b0; mem_daddr_i = 32'h0;
    exc_adel_if_i = 1'b0; exc_ri_i = 1'b0; exc_ov_i = 1'b0; exc_trap_i = 1'b0;
    exc_sys_i = 1'b0; exc_bp_i = 1'b0; exc_eret_i = 1'b0; exc_adel_ld_i = 1'b0;
    exc_ades_i = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the next expected commit and compare the CP0 port against it
  task automatic commit_cmp(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'h1, 32'h0);
      return;
    end
    cur = sb.pop_front();
    chk({tag, "_code"},  excepttype_o,        cur.code);
    chk({tag, "_pc"},    current_inst_addr_o, cur.pc);
    chk({tag, "_ds"},    32'(is_in_delayslot_o), 32'(cur.ds));
    chk({tag, "_bad"},   bad_addr_o,          cur.bad);
    chk({tag, "_npc"},   newpc_o,             cur.npc);
    chk({tag, "_flush"}, 32'(flush_o),        32'h1);
    chk({tag, "_busy"},  32'(busy_o),         32'h1);
  endtask

  // Caller has driven a detecting instruction; check kill, then the commit cycle
  task automatic fire(input string tag, input exp_t e);
    #1;
    chk({tag, "_kill"}, 32'(mem_kill_o), 32'h1);
    sb.push_back(e);
    step();
    clear_in();
    commit_cmp(tag);
  endtask

  task automatic drain_chk(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk({tag, "_dr_flush"}, 32'(flush_o), 32'h1);
      chk({tag, "_dr_code"},  excepttype_o, 32'h0);
      chk({tag, "_dr_npc"},   newpc_o,      cur.npc);
    end
    step();
    chk({tag, "_idle_busy"},  32'(busy_o),  32'h0);
    chk({tag, "_idle_flush"}, 32'(flush_o), 32'h0);
    chk({tag, "_idle_npc"},   newpc_o,      32'h0);
  endtask

  initial begin
    clear_in();
    stall_i = 1'b0; cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    rst = 1'b1;
    step();
    mem_valid_i = 1'b1; exc_sys_i = 1'b1;
    #1;
    chk("rst_kill", 32'(mem_kill_o), 32'h0);
    step();
    chk("rst_flush", 32'(flush_o), 32'h0);
    chk("rst_busy",  32'(busy_o),  32'h0);
    chk("rst_code",  excepttype_o, 32'h0);
    chk("rst_npc",   newpc_o,      32'h0);
    clear_in();
    rst = 1'b0;
    step();

    // syscall, full drain timing
    mem_valid_i = 1'b1; mem_pc_i = 32'hBFC00100; exc_sys_i = 1'b1;
    fire("sys", '{32'h08, 32'hBFC00100, 1'b0, 32'h0, VEC});
    drain_chk("sys", 2);

    // ov outranks adel_ld
    mem_valid_i = 1'b1; mem_pc_i = 32'h80001000; mem_daddr_i = 32'h80000003;
    exc_ov_i = 1'b1; exc_adel_ld_i = 1'b1;
    fire("ov", '{32'h0c, 32'h80001000, 1'b0, 32'h0, VEC});
    drain_chk("ov", 2);
    mem_valid_i = 1'b1; mem_pc_i = 32'h80001004; mem_daddr_i = 32'h80000003;
    mem_in_delayslot_i = 1'b1; exc_adel_ld_i = 1'b1;
    fire("adel_ld", '{32'h04, 32'h80001004, 1'b1, 32'h80000003, VEC});
    drain_chk("adel_ld", 2);

    // interrupt outranks syscall, masked by EXL
    cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00008000;
    mem_valid_i = 1'b1; mem_pc_i = 32'h80002000; exc_sys_i = 1'b1;
    fire("int", '{32'h01, 32'h80002000, 1'b0, 32'h0, VEC});
    drain_chk("int", 2);
    cp0_status_i = 32'h0000FF03;
    mem_valid_i = 1'b1; mem_pc_i = 32'h80002004; exc_sys_i = 1'b1;
    fire("int_exl", '{32'h08, 32'h80002004, 1'b0, 32'h0, VEC});
    drain_chk("int_exl", 2);
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0;

    // eret redirects to EPC
    cp0_epc_i = 32'hBFC01234;
    mem_valid_i = 1'b1; mem_pc_i = 32'h80003000; exc_eret_i = 1'b1;
    fire("eret", '{32'h0e, 32'h80003000, 1'b0, 32'h0, 32'hBFC01234});
    drain_chk("eret", 2);

    // stall in IDLE blocks detection
    stall_i = 1'b1;
    mem_valid_i = 1'b1; mem_pc_i = 32'h80004000; mem_daddr_i = 32'h10000002; exc_ades_i = 1'b1;
    #1;
    chk("idle_stall_kill", 32'(mem_kill_o), 32'h0);
    step();
    chk("idle_stall_busy", 32'(busy_o), 32'h0);
    stall_i = 1'b0;

    // ades with 3 stalled COMMIT cycles, then a flag during DRAIN is ignored
    #1;
    chk("ades_kill", 32'(mem_kill_o), 32'h1);
    sb.push_back('{32'h05, 32'h80004000, 1'b0, 32'h10000002, VEC});
    step();
    clear_in();
    stall_i = 1'b1;
    commit_cmp("ades");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_hold_code",  excepttype_o, 32'h05);
      chk("stall_hold_flush", 32'(flush_o), 32'h1);
    end
    stall_i = 1'b0;
    step();
    chk("post_stall_code",  excepttype_o, 32'h0);
    chk("post_stall_flush", 32'(flush_o), 32'h1);
    mem_valid_i = 1'b1; mem_pc_i = 32'h80004004; exc_bp_i = 1'b1;
    #1;
    chk("drain_kill", 32'(mem_kill_o), 32'h0);
    step();
    clear_in();
    chk("drain_code", excepttype_o, 32'h0);
    step();
    chk("drain_ignored_busy", 32'(busy_o), 32'h0);
    chk("drain_ignored_code", excepttype_o, 32'h0);

    // reset in DRAIN, then immediate new detect
    mem_valid_i = 1'b1; mem_pc_i = 32'h80005000; exc_bp_i = 1'b1;
    fire("bp", '{32'h09, 32'h80005000, 1'b0, 32'h0, VEC});
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_flush", 32'(flush_o), 32'h0);
    chk("mid_rst_busy",  32'(busy_o),  32'h0);
    chk("mid_rst_code",  excepttype_o, 32'h0);
    chk("mid_rst_npc",   newpc_o,      32'h0);
    mem_valid_i = 1'b1; mem_pc_i = 32'hBFC00002; exc_adel_if_i = 1'b1; exc_ri_i = 1'b1;
    fire("adel_if", '{32'h04, 32'hBFC00002, 1'b0, 32'hBFC00002, VEC});
    drain_chk("adel_if", 2);

    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
